hazard_ctrl: RTL and testbench
==============================

Name: hazard_ctrl

Overview:
- Pipeline hazard controller that sequences the EX-stage ALU datapath and the stage registers around it (FD, DX, XM, MW).
- Detects load-use hazards and inserts one bubble.
- Generates ALU operand forwarding selects and squashes wrong-path instructions when a taken branch is registered in XM.
- Freezes the whole pipeline while data memory is busy.
- Keeps saturating stall/flush performance counters.

Parameters:
CNT_W, 16, width of each performance counter
REG_W, 5, register-specifier width

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-low
FD_RS  in  REG_W  rs of instruction in ID
FD_RT  in  REG_W  rt of instruction in ID
FD_uses_rt  in  1  ID instruction reads rt (R-type, beq/bne, sw)
DX_RS  in  REG_W  rs of instruction in EX
DX_RT  in  REG_W  rt of instruction in EX
DX_MemRead  in  1  EX instruction is a load
DX_RD  in  REG_W  destination of EX instruction
XM_RegWrite  in  1  MEM instruction writes the register file
XM_RD  in  REG_W  destination of MEM instruction
MW_RegWrite  in  1  WB instruction writes the register file
MW_RD  in  REG_W  destination of WB instruction
XM_branch  in  1  taken branch registered in XM
mem_busy  in  1  data memory not ready; freeze pipeline
PC_write  out  1  PC update enable
PC_sel_bt  out  1  PC loads XM_BT instead of PC+4
FD_write  out  1  FD register enable
FD_flush  out  1  FD loads NOP
DX_write  out  1  DX register enable
DX_bubble  out  1  DX loads zeroed control bits
XM_write  out  1  XM/MW register enable
XM_kill  out  1  XM loads zeroed control bits
fwd_A  out  2  ALU A source: 00 DX_A, 10 XM ALUout, 01 MW write-back data
fwd_B  out  2  ALU B source, same encoding
state  out  2  FSM state, for debug
stall_cnt  out  CNT_W  load-use stall cycles, saturating
flush_cnt  out  CNT_W  branch flush events, saturating

Behaviour:
- Reset (rst=0, asynchronous): state=RUN, stall_cnt=0, flush_cnt=0.
- All control outputs are combinational from state and inputs.
- During reset, outputs take their RUN values for the current inputs.
- Load-use condition (lu): DX_MemRead && DX_RD!=0 && (DX_RD==FD_RS || (FD_uses_rt && DX_RD==FD_RT)).
- Forwarding, evaluated independently per operand:
  - fwd_A=10 if XM_RegWrite && XM_RD!=0 && XM_RD==DX_RS;
  - else fwd_A=01 if MW_RegWrite && MW_RD!=0 && MW_RD==DX_RS;
  - else 00. fwd_B uses DX_RT the same way.
  - XM has priority over MW. Register 0 never forwards.
  - Forwarding is active in every state, including freeze.
- Defaults: all *_write=1; flush/bubble/kill=0; PC_sel_bt=0.
- Priority, highest first: mem_busy > XM_branch > lu.
- mem_busy=1 (any state):
  - PC_write=FD_write=DX_write=XM_write=0; all flush/bubble/kill=0.
  - State and counters hold.
  - A pending XM_branch is serviced in the first cycle mem_busy=0, because XM holds.
- FSM states:
  - RUN:
    - XM_branch=1: PC_sel_bt=1, FD_flush=1, DX_bubble=1, XM_kill=1; flush_cnt+1; next BR_FLUSH.
    - else lu=1: PC_write=0, FD_write=0, DX_bubble=1; stall_cnt+1; next LU_STALL.
    - else stay RUN.
  - LU_STALL: exactly one bubble.
    - Load now in MEM; consumer stays in ID and gets MW forwarding next cycle.
    - lu is not re-evaluated. XM_branch=1 is handled as in RUN (flush, go BR_FLUSH).
    - Otherwise next RUN with default outputs.
  - BR_FLUSH: FD and DX hold squashed NOPs.
    - lu is masked. XM_branch is ignored (XM holds the killed instruction).
    - Default outputs; next RUN.
- Counters: saturate at all ones and never wrap. No increment while mem_busy=1.
- Encoding: RUN=2'b00, LU_STALL=2'b01, BR_FLUSH=2'b10. 2'b11 is illegal and recovers to RUN next cycle with default outputs.
- Reset mid-stall or mid-flush returns to RUN immediately; the killed or bubbled instruction is not replayed.

Decomposition:
- Shared package holds:
  - state encodings ST_RUN, ST_LU_STALL, ST_BR_FLUSH;
  - forwarding encodings FWD_REG=2'b00, FWD_MW=2'b01, FWD_XM=2'b10;
  - REG_ZERO constant.
- One sub-module, fwd_unit: purely combinational forwarding select, instanced once per ALU operand.

Test Plan:
- Reset: rst=0 mid-run with state=LU_STALL -> state=00, stall_cnt=0, flush_cnt=0 asynchronously, with no clock edge.
- Load-use: DX_MemRead=1, DX_RD=8, FD_RS=8 -> PC_write=0, FD_write=0, DX_bubble=1 for exactly one cycle, then RUN; stall_cnt=1.
- Load-use on unused rt: DX_RD=8, FD_RT=8, FD_uses_rt=0 -> no stall. DX_RD=0 with FD_RS=0 -> no stall.
- Forwarding priority: XM_RD=MW_RD=DX_RS=5, both RegWrite=1 -> fwd_A=10. XM_RegWrite=0 -> fwd_A=01. DX_RS=0 -> fwd_A=00.
- Branch with simultaneous lu: XM_branch=1 and lu=1 in RUN -> PC_sel_bt=1, FD_flush=DX_bubble=XM_kill=1, PC_write=1. Next cycle BR_FLUSH with lu masked; flush_cnt=1, stall_cnt=0.
- Freeze and saturation: mem_busy=1 for 3 cycles during XM_branch=1 -> all write enables 0, state held. Branch serviced in the cycle mem_busy drops. Preloading stall_cnt to all ones then causing a stall -> stall_cnt stays 16'hFFFF.

Source files
------------

// File: rtl/hazard_ctrl_pkg.sv
// Shared encodings for the pipeline hazard controller: FSM states,
// ALU operand forwarding selects and the hard-wired zero register.
package hazard_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_RUN      = 2'b00,
        ST_LU_STALL = 2'b01,
        ST_BR_FLUSH = 2'b10,
        ST_ILLEGAL  = 2'b11
    } state_e;

    localparam logic [1:0] FWD_REG = 2'b00;
    localparam logic [1:0] FWD_MW  = 2'b01;
    localparam logic [1:0] FWD_XM  = 2'b10;

    localparam int unsigned REG_ZERO = 0;

endpackage : hazard_ctrl_pkg

// File: rtl/hazard_ctrl_fwd_unit.sv
// ALU operand forwarding select for one EX-stage source register.
// Ports:
//   src          register specifier read by the EX instruction
//   xm_regwrite  MEM instruction writes the register file
//   xm_rd        MEM instruction destination
//   mw_regwrite  WB instruction writes the register file
//   mw_rd        WB instruction destination
//   sel          FWD_XM / FWD_MW / FWD_REG (combinational)
module hazard_ctrl_fwd_unit
    import hazard_ctrl_pkg::*;
#(
    parameter int unsigned REG_W = 5
) (
    input  logic [REG_W-1:0] src,
    input  logic             xm_regwrite,
    input  logic [REG_W-1:0] xm_rd,
    input  logic             mw_regwrite,
    input  logic [REG_W-1:0] mw_rd,
    output logic [1:0]       sel
);

    logic xm_hit;
    logic mw_hit;

    // Register 0 is hard-wired, so a write to it never produces a forward.
    assign xm_hit = xm_regwrite && (xm_rd != REG_W'(REG_ZERO)) && (xm_rd == src);
    assign mw_hit = mw_regwrite && (mw_rd != REG_W'(REG_ZERO)) && (mw_rd == src);

    // The younger result (XM) wins over the older one (MW).
    always_comb begin
        sel = FWD_REG;
        if (xm_hit) begin
            sel = FWD_XM;
        end else if (mw_hit) begin
            sel = FWD_MW;
        end
    end

endmodule : hazard_ctrl_fwd_unit

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller around the EX-stage ALU datapath.
// Inserts one bubble on load-use, squashes wrong-path instructions on a
// taken branch in XM, freezes everything while data memory is busy,
// generates ALU forwarding selects and keeps saturating perf counters.
// Ports:
//   clk, rst                  clock / async active-low reset
//   FD_*, DX_*, XM_*, MW_*    register specifiers and control of each stage
//   XM_branch, mem_busy       taken branch in MEM / data memory stall
//   PC_*, FD_*, DX_*, XM_*    stage enables and squash controls (combinational)
//   fwd_A, fwd_B              ALU operand selects (combinational)
//   state                     FSM state (registered)
//   stall_cnt, flush_cnt      load-use stall / branch flush counters (registered)
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int unsigned CNT_W = 16,
    parameter int unsigned REG_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [REG_W-1:0] FD_RS,
    input  logic [REG_W-1:0] FD_RT,
    input  logic             FD_uses_rt,
    input  logic [REG_W-1:0] DX_RS,
    input  logic [REG_W-1:0] DX_RT,
    input  logic             DX_MemRead,
    input  logic [REG_W-1:0] DX_RD,
    input  logic             XM_RegWrite,
    input  logic [REG_W-1:0] XM_RD,
    input  logic             MW_RegWrite,
    input  logic [REG_W-1:0] MW_RD,
    input  logic             XM_branch,
    input  logic             mem_busy,
    output logic             PC_write,
    output logic             PC_sel_bt,
    output logic             FD_write,
    output logic             FD_flush,
    output logic             DX_write,
    output logic             DX_bubble,
    output logic             XM_write,
    output logic             XM_kill,
    output logic [1:0]       fwd_A,
    output logic [1:0]       fwd_B,
    output logic [1:0]       state,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    state_e           state_q;
    state_e           state_d;
    logic [CNT_W-1:0] stall_q;
    logic [CNT_W-1:0] flush_q;
    logic             stall_inc;
    logic             flush_inc;
    logic             lu;

    // Load in EX feeding a register the ID instruction actually reads.
    assign lu = DX_MemRead && (DX_RD != REG_W'(REG_ZERO)) &&
                ((DX_RD == FD_RS) || (FD_uses_rt && (DX_RD == FD_RT)));

    // One forwarding unit per ALU operand; active regardless of FSM state.
    hazard_ctrl_fwd_unit #(.REG_W(REG_W)) u_fwd_a (
        .src         (DX_RS),
        .xm_regwrite (XM_RegWrite),
        .xm_rd       (XM_RD),
        .mw_regwrite (MW_RegWrite),
        .mw_rd       (MW_RD),
        .sel         (fwd_A)
    );

    hazard_ctrl_fwd_unit #(.REG_W(REG_W)) u_fwd_b (
        .src         (DX_RT),
        .xm_regwrite (XM_RegWrite),
        .xm_rd       (XM_RD),
        .mw_regwrite (MW_RegWrite),
        .mw_rd       (MW_RD),
        .sel         (fwd_B)
    );

    // State register and saturating counters.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_RUN;
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            state_q <= state_d;
            if (stall_inc && (stall_q != {CNT_W{1'b1}})) begin
                stall_q <= stall_q + CNT_W'(1);
            end
            if (flush_inc && (flush_q != {CNT_W{1'b1}})) begin
                flush_q <= flush_q + CNT_W'(1);
            end
        end
    end

    // Next state and stage controls. mem_busy freezes every stage; because
    // XM holds, a pending branch is still there once memory frees up.
    always_comb begin
        state_d   = state_q;
        PC_write  = 1'b1;
        PC_sel_bt = 1'b0;
        FD_write  = 1'b1;
        FD_flush  = 1'b0;
        DX_write  = 1'b1;
        DX_bubble = 1'b0;
        XM_write  = 1'b1;
        XM_kill   = 1'b0;
        stall_inc = 1'b0;
        flush_inc = 1'b0;

        if (mem_busy) begin
            PC_write = 1'b0;
            FD_write = 1'b0;
            DX_write = 1'b0;
            XM_write = 1'b0;
        end else begin
            case (state_q)
                ST_RUN, ST_LU_STALL: begin
                    if (XM_branch) begin
                        PC_sel_bt = 1'b1;
                        FD_flush  = 1'b1;
                        DX_bubble = 1'b1;
                        XM_kill   = 1'b1;
                        flush_inc = 1'b1;
                        state_d   = ST_BR_FLUSH;
                    end else if ((state_q == ST_RUN) && lu) begin
                        PC_write  = 1'b0;
                        FD_write  = 1'b0;
                        DX_bubble = 1'b1;
                        stall_inc = 1'b1;
                        state_d   = ST_LU_STALL;
                    end else begin
                        // After the single bubble the consumer picks the
                        // load result up through MW forwarding.
                        state_d = ST_RUN;
                    end
                end
                // FD/DX hold squashed NOPs and XM holds the killed branch,
                // so neither lu nor XM_branch is meaningful this cycle.
                ST_BR_FLUSH: state_d = ST_RUN;
                default:     state_d = ST_RUN;
            endcase
        end
    end

    assign state     = state_q;
    assign stall_cnt = stall_q;
    assign flush_cnt = flush_q;

endmodule : hazard_ctrl

// File: tb/tb_hazard_ctrl.sv
// Directed self-checking bench for hazard_ctrl.
module tb_hazard_ctrl;

    logic       clk;
    logic       rst;
    logic [4:0] FD_RS, FD_RT, DX_RS, DX_RT, DX_RD, XM_RD, MW_RD;
    logic       FD_uses_rt, DX_MemRead, XM_RegWrite, MW_RegWrite, XM_branch, mem_busy;
    logic       PC_write, PC_sel_bt, FD_write, FD_flush, DX_write, DX_bubble, XM_write, XM_kill;
    logic [1:0] fwd_A, fwd_B, state;
    logic [15:0] stall_cnt, flush_cnt;

    // Narrow-counter instance used to reach saturation quickly.
    logic       s_PC_write, s_PC_sel_bt, s_FD_write, s_FD_flush, s_DX_write, s_DX_bubble;
    logic       s_XM_write, s_XM_kill;
    logic [1:0] s_fwd_A, s_fwd_B, s_state;
    logic [2:0] s_stall_cnt, s_flush_cnt;

    int n_cmp;
    int n_err;

    hazard_ctrl #(.CNT_W(16), .REG_W(5)) dut (
        .clk(clk), .rst(rst),
        .FD_RS(FD_RS), .FD_RT(FD_RT), .FD_uses_rt(FD_uses_rt),
        .DX_RS(DX_RS), .DX_RT(DX_RT), .DX_MemRead(DX_MemRead), .DX_RD(DX_RD),
        .XM_RegWrite(XM_RegWrite), .XM_RD(XM_RD),
        .MW_RegWrite(MW_RegWrite), .MW_RD(MW_RD),
        .XM_branch(XM_branch), .mem_busy(mem_busy),
        .PC_write(PC_write), .PC_sel_bt(PC_sel_bt),
        .FD_write(FD_write), .FD_flush(FD_flush),
        .DX_write(DX_write), .DX_bubble(DX_bubble),
        .XM_write(XM_write), .XM_kill(XM_kill),
        .fwd_A(fwd_A), .fwd_B(fwd_B), .state(state),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    hazard_ctrl #(.CNT_W(3), .REG_W(5)) dut_sat (
        .clk(clk), .rst(rst),
        .FD_RS(FD_RS), .FD_RT(FD_RT), .FD_uses_rt(FD_uses_rt),
        .DX_RS(DX_RS), .DX_RT(DX_RT), .DX_MemRead(DX_MemRead), .DX_RD(DX_RD),
        .XM_RegWrite(XM_RegWrite), .XM_RD(XM_RD),
        .MW_RegWrite(MW_RegWrite), .MW_RD(MW_RD),
        .XM_branch(XM_branch), .mem_busy(mem_busy),
        .PC_write(s_PC_write), .PC_sel_bt(s_PC_sel_bt),
        .FD_write(s_FD_write), .FD_flush(s_FD_flush),
        .DX_write(s_DX_write), .DX_bubble(s_DX_bubble),
        .XM_write(s_XM_write), .XM_kill(s_XM_kill),
        .fwd_A(s_fwd_A), .fwd_B(s_fwd_B), .state(s_state),
        .stall_cnt(s_stall_cnt), .flush_cnt(s_flush_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic idle();
        FD_RS = '0; FD_RT = '0; FD_uses_rt = 1'b0;
        DX_RS = '0; DX_RT = '0; DX_MemRead = 1'b0; DX_RD = '0;
        XM_RegWrite = 1'b0; XM_RD = '0; MW_RegWrite = 1'b0; MW_RD = '0;
        XM_branch = 1'b0; mem_busy = 1'b0;
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        rst = 1'b0;
        #1;
        rst = 1'b1;
    endtask

    task automatic test_reset();
        #3;
        n_cmp++; if (state !== 2'b00) begin n_err++; $display("FAIL rst_state: got %b want 00", state); end
        n_cmp++; if (stall_cnt !== 16'd0 || flush_cnt !== 16'd0) begin n_err++; $display("FAIL rst_cnt: got %h/%h want 0/0", stall_cnt, flush_cnt); end
        n_cmp++; if ({PC_write, FD_write, DX_write, XM_write, DX_bubble} !== 5'b11110) begin n_err++; $display("FAIL rst_outs: got %b want 11110", {PC_write, FD_write, DX_write, XM_write, DX_bubble}); end
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_load_use();
        @(negedge clk);
        DX_MemRead = 1'b1; DX_RD = 5'd8; FD_RS = 5'd8;
        #1;
        n_cmp++; if ({PC_write, FD_write, DX_bubble, DX_write} !== 4'b0011) begin n_err++; $display("FAIL lu_ctrl: got %b want 0011", {PC_write, FD_write, DX_bubble, DX_write}); end
        @(negedge clk);
        #1;
        n_cmp++; if (state !== 2'b01) begin n_err++; $display("FAIL lu_state: got %b want 01", state); end
        // lu is still true but must not produce a second bubble.
        n_cmp++; if ({PC_write, FD_write, DX_bubble} !== 3'b110) begin n_err++; $display("FAIL lu_one_bubble: got %b want 110", {PC_write, FD_write, DX_bubble}); end
        n_cmp++; if (stall_cnt !== 16'd1) begin n_err++; $display("FAIL lu_cnt: got %0d want 1", stall_cnt); end
        @(negedge clk);
        idle();
        #1;
        n_cmp++; if (state !== 2'b00) begin n_err++; $display("FAIL lu_back_run: got %b want 00", state); end
    endtask

    task automatic test_lu_unused_rt();
        @(negedge clk);
        DX_MemRead = 1'b1; DX_RD = 5'd8; FD_RT = 5'd8; FD_RS = 5'd3; FD_uses_rt = 1'b0;
        #1;
        n_cmp++; if ({PC_write, DX_bubble} !== 2'b10) begin n_err++; $display("FAIL lu_rt_unused: got %b want 10", {PC_write, DX_bubble}); end
        @(negedge clk);
        DX_RD = 5'd0; FD_RS = 5'd0; FD_RT = 5'd0;
        #1;
        n_cmp++; if ({PC_write, DX_bubble, state} !== 4'b1000) begin n_err++; $display("FAIL lu_r0: got %b want 1000", {PC_write, DX_bubble, state}); end
        @(negedge clk);
        DX_RD = 5'd8; FD_RT = 5'd8; FD_RS = 5'd3; FD_uses_rt = 1'b1;
        #1;
        n_cmp++; if ({PC_write, FD_write, DX_bubble} !== 3'b001) begin n_err++; $display("FAIL lu_rt_used: got %b want 001", {PC_write, FD_write, DX_bubble}); end
        @(negedge clk);
        idle();
        #1;
        n_cmp++; if (state !== 2'b01 || stall_cnt !== 16'd2) begin n_err++; $display("FAIL lu_rt_cnt: got %b/%0d want 01/2", state, stall_cnt); end
        @(negedge clk);
    endtask

    task automatic test_forwarding();
        @(negedge clk);
        XM_RegWrite = 1'b1; MW_RegWrite = 1'b1; XM_RD = 5'd5; MW_RD = 5'd5; DX_RS = 5'd5; DX_RT = 5'd9;
        #1;
        n_cmp++; if (fwd_A !== 2'b10 || fwd_B !== 2'b00) begin n_err++; $display("FAIL fwd_xm_prio: got %b/%b want 10/00", fwd_A, fwd_B); end
        XM_RegWrite = 1'b0;
        #1;
        n_cmp++; if (fwd_A !== 2'b01) begin n_err++; $display("FAIL fwd_mw: got %b want 01", fwd_A); end
        XM_RegWrite = 1'b1; XM_RD = 5'd0; MW_RD = 5'd0; DX_RS = 5'd0;
        #1;
        n_cmp++; if (fwd_A !== 2'b00) begin n_err++; $display("FAIL fwd_r0: got %b want 00", fwd_A); end
        // Forwarding stays live while frozen.
        mem_busy = 1'b1; XM_RD = 5'd9; MW_RD = 5'd7; DX_RS = 5'd7;
        #1;
        n_cmp++; if (fwd_B !== 2'b10 || fwd_A !== 2'b01 || PC_write !== 1'b0) begin n_err++; $display("FAIL fwd_freeze: got %b/%b/%b want 10/01/0", fwd_B, fwd_A, PC_write); end
        @(negedge clk);
        idle();
    endtask

    task automatic test_branch_lu();
        pulse_reset();
        DX_MemRead = 1'b1; DX_RD = 5'd8; FD_RS = 5'd8; XM_branch = 1'b1;
        #1;
        n_cmp++; if ({PC_sel_bt, FD_flush, DX_bubble, XM_kill, PC_write, FD_write} !== 6'b111111) begin n_err++; $display("FAIL br_lu_ctrl: got %b want 111111", {PC_sel_bt, FD_flush, DX_bubble, XM_kill, PC_write, FD_write}); end
        @(negedge clk);
        #1;
        n_cmp++; if (state !== 2'b10 || flush_cnt !== 16'd1 || stall_cnt !== 16'd0) begin n_err++; $display("FAIL br_lu_next: got %b/%0d/%0d want 10/1/0", state, flush_cnt, stall_cnt); end
        n_cmp++; if ({PC_sel_bt, FD_flush, DX_bubble, XM_kill, PC_write} !== 5'b00001) begin n_err++; $display("FAIL br_flush_masked: got %b want 00001", {PC_sel_bt, FD_flush, DX_bubble, XM_kill, PC_write}); end
        @(negedge clk);
        idle();
        #1;
        n_cmp++; if (state !== 2'b00 || flush_cnt !== 16'd1) begin n_err++; $display("FAIL br_back_run: got %b/%0d want 00/1", state, flush_cnt); end
    endtask

    task automatic test_freeze();
        @(negedge clk);
        mem_busy = 1'b1; XM_branch = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_cmp++; if ({PC_write, FD_write, DX_write, XM_write, PC_sel_bt, XM_kill} !== 6'b000000) begin n_err++; $display("FAIL frz_ctrl%0d: got %b want 000000", i, {PC_write, FD_write, DX_write, XM_write, PC_sel_bt, XM_kill}); end
            @(negedge clk);
            n_cmp++; if (state !== 2'b00 || flush_cnt !== 16'd1) begin n_err++; $display("FAIL frz_hold%0d: got %b/%0d want 00/1", i, state, flush_cnt); end
        end
        mem_busy = 1'b0;
        #1;
        n_cmp++; if ({PC_sel_bt, XM_kill, FD_flush, XM_write} !== 4'b1111) begin n_err++; $display("FAIL frz_release: got %b want 1111", {PC_sel_bt, XM_kill, FD_flush, XM_write}); end
        @(negedge clk);
        idle();
        #1;
        n_cmp++; if (state !== 2'b10 || flush_cnt !== 16'd2) begin n_err++; $display("FAIL frz_br_done: got %b/%0d want 10/2", state, flush_cnt); end
        // Freeze while in LU_STALL holds the state.
        @(negedge clk);
        DX_MemRead = 1'b1; DX_RD = 5'd4; FD_RS = 5'd4;
        @(negedge clk);
        idle();
        mem_busy = 1'b1;
        @(negedge clk);
        #1;
        n_cmp++; if (state !== 2'b01 || stall_cnt !== 16'd1) begin n_err++; $display("FAIL frz_lu_hold: got %b/%0d want 01/1", state, stall_cnt); end
        mem_busy = 1'b0;
        @(negedge clk);
        #1;
        n_cmp++; if (state !== 2'b00) begin n_err++; $display("FAIL frz_lu_exit: got %b want 00", state); end
    endtask

    task automatic test_async_reset();
        @(negedge clk);
        DX_MemRead = 1'b1; DX_RD = 5'd6; FD_RS = 5'd6;
        @(negedge clk);
        idle();
        #1;
        n_cmp++; if (state !== 2'b01) begin n_err++; $display("FAIL arst_pre: got %b want 01", state); end
        rst = 1'b0;
        #1;
        n_cmp++; if (state !== 2'b00 || stall_cnt !== 16'd0 || flush_cnt !== 16'd0) begin n_err++; $display("FAIL arst_now: got %b/%0d/%0d want 00/0/0", state, stall_cnt, flush_cnt); end
        #1;
        rst = 1'b1;
    endtask

    task automatic test_saturation();
        pulse_reset();
        DX_MemRead = 1'b1; DX_RD = 5'd8; FD_RS = 5'd8;
        repeat (14) @(negedge clk);
        #1;
        n_cmp++; if (stall_cnt !== 16'd7 || s_stall_cnt !== 3'd7) begin n_err++; $display("FAIL sat_stall_7: got %0d/%0d want 7/7", stall_cnt, s_stall_cnt); end
        repeat (6) @(negedge clk);
        #1;
        n_cmp++; if (stall_cnt !== 16'd10 || s_stall_cnt !== 3'd7) begin n_err++; $display("FAIL sat_stall_hold: got %0d/%0d want 10/7", stall_cnt, s_stall_cnt); end
        idle();
        pulse_reset();
        XM_branch = 1'b1;
        repeat (20) @(negedge clk);
        #1;
        n_cmp++; if (flush_cnt !== 16'd10 || s_flush_cnt !== 3'd7) begin n_err++; $display("FAIL sat_flush_hold: got %0d/%0d want 10/7", flush_cnt, s_flush_cnt); end
        idle();
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst = 1'b0;
        idle();
        test_reset();
        test_load_use();
        test_lu_unused_rt();
        test_forwarding();
        test_branch_lu();
        test_freeze();
        test_async_reset();
        test_saturation();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_hazard_ctrl
